// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and constants: redirect kinds, instruction/word sizing and
// the redirect target computation used by pc_fetch_unit.
package fetch_pkg;

   localparam int unsigned INSN_W     = 32;
   localparam int unsigned WORD_SHIFT = 2;

   typedef enum logic [1:0] {
      REDIR_NONE,
      REDIR_JUMP,
      REDIR_BRANCH
   } redir_kind_e;

   // Computed at 64 bits; the caller truncates to its address width, which also gives
   // the jump region bits pc[ADDR_W-1:28] and the wrapping branch sum.
   function automatic logic [63:0] redir_target_calc(
      input redir_kind_e  kind,
      input logic [63:0]  pc,
      input logic [25:0]  target,
      input logic [15:0]  imm
   );
      logic [63:0] seq_pc;
      logic [63:0] offset;
      logic [63:0] result;
      seq_pc = pc + 64'(1 << WORD_SHIFT);
      offset = 64'(signed'(imm)) << WORD_SHIFT;
      unique case (kind)
         REDIR_JUMP:   result = {pc[63:28], target, 2'b00};
         REDIR_BRANCH: result = seq_pc + offset;
         default:      result = pc;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO with synchronous flush and occupancy count; holds request PCs
// or {pc, instruction} words for the fetch unit.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head_data,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   always_comb begin
      head_valid = (count != '0);
      do_pop     = pop & head_valid;
      do_push    = push & ~flush & ((count != DEPTH_C) | do_pop);
      head_data  = mem[rd_ptr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// In-order instruction fetch front end with credit-limited reads, redirect flush and drop counting.
// Optional IF_PERF_CNT_EN adds stall and flush performance counters.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 'hBFC0_0000,
   parameter int unsigned        DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSN_W-1:0]  imem_rsp_data,
   output logic               ins_valid,
   output logic [INSN_W-1:0]  ins_data,
   output logic [ADDR_W-1:0]  ins_pc,
   input  logic               ins_ready,
   input  logic               redir_valid,
   input  logic               redir_jmp,
   input  logic               redir_ne,
   input  logic               redir_z,
   input  logic [ADDR_W-1:0]  redir_pc,
   input  logic [25:0]        redir_target,
   input  logic [15:0]        redir_imm
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned QW = ADDR_W + INSN_W;
   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] redir_addr;
   logic              running;
   logic [CW-1:0]     tag_count;
   logic [CW-1:0]     q_count;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     drop_after;
   logic [CW:0]       credit;
   logic              accept;
   logic              taken;
   logic              rsp_pop;
   logic              rsp_keep;
   logic              pop;
   redir_kind_e       kind;
   logic [ADDR_W-1:0] tag_pc;
   logic              tag_valid;
   logic [QW-1:0]     q_head;
   logic              q_valid;

   always_comb begin
      credit         = {1'b0, tag_count} + {1'b0, q_count};
      imem_req_valid = running && (credit < DEPTH_C);
      imem_req_addr  = pc;
      accept         = imem_req_valid & imem_req_ready;
      taken          = redir_valid & (redir_jmp | (redir_ne ? ~redir_z : redir_z));
      kind           = !taken ? REDIR_NONE : (redir_jmp ? REDIR_JUMP : REDIR_BRANCH);
      redir_addr     = ADDR_W'(redir_target_calc(kind, 64'(redir_pc), redir_target, redir_imm));
      rsp_pop        = imem_rsp_valid & tag_valid;
      rsp_keep       = rsp_pop & (drop == '0) & ~taken;
      // Every read still in flight after this edge is wrong-path once a redirect is taken.
      drop_after     = tag_count + CW'(accept) - CW'(rsp_pop);
      pop            = q_valid & ins_ready;
      ins_valid      = q_valid;
      ins_data       = q_valid ? q_head[INSN_W-1:0] : '0;
      ins_pc         = q_valid ? q_head[QW-1:INSN_W] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= RESET_PC;
         drop    <= '0;
         running <= 1'b0;
      end else begin
         running <= 1'b1;
         if (taken)       pc <= redir_addr;
         else if (accept) pc <= pc + ADDR_W'(1 << WORD_SHIFT);
         if (taken)                          drop <= drop_after;
         else if (rsp_pop && drop != '0)     drop <= drop - CW'(1);
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .W     (ADDR_W)
   ) u_tag_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (1'b0),
      .push       (accept),
      .push_data  (pc),
      .pop        (rsp_pop),
      .head_data  (tag_pc),
      .head_valid (tag_valid),
      .count      (tag_count)
   );

   fetch_queue #(
      .DEPTH (DEPTH),
      .W     (QW)
   ) u_insn_queue (
      .clk        (clk),
      .rst        (rst),
      .flush      (taken),
      .push       (rsp_keep),
      .push_data  ({tag_pc, imem_rsp_data}),
      .pop        (pop),
      .head_data  (q_head),
      .head_valid (q_valid),
      .count      (q_count)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (!q_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (taken)    perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential stream, decode stall, redirect vector table,
// same-cycle redirect/response/accept, address wrap and mid-operation reset.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] NT_ACC   = 32'hBFC0_000C;
   localparam logic [31:0] NT_POP   = 32'hBFC0_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ins_valid;
   logic [31:0] ins_data;
   logic [31:0] ins_pc;
   logic        ins_ready;
   logic        redir_valid;
   logic        redir_jmp;
   logic        redir_ne;
   logic        redir_z;
   logic [31:0] redir_pc;
   logic [25:0] redir_target;
   logic [15:0] redir_imm;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .ins_valid      (ins_valid),
      .ins_data       (ins_data),
      .ins_pc         (ins_pc),
      .ins_ready      (ins_ready),
      .redir_valid    (redir_valid),
      .redir_jmp      (redir_jmp),
      .redir_ne       (redir_ne),
      .redir_z        (redir_z),
      .redir_pc       (redir_pc),
      .redir_target   (redir_target),
      .redir_imm      (redir_imm)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   typedef struct {
      string       name;
      logic        valid;
      logic        jmp;
      logic        ne;
      logic        z;
      logic [31:0] pc;
      logic [25:0] tgt;
      logic [15:0] imm;
      logic [31:0] exp_acc;
      logic [31:0] exp_pop;
   } redir_vec_t;

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   logic [31:0] acc_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_data_q[$];
   logic        rsp_pend;
   logic [31:0] rsp_addr;
   logic        mem_ready;
   logic        last_acc;
   logic        last_rsp;
   redir_vec_t  vecs[8];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   function automatic redir_vec_t mk(input string n, input logic v, input logic j, input logic ne,
                                     input logic z, input logic [31:0] pc, input logic [25:0] t,
                                     input logic [15:0] imm, input logic [31:0] ea,
                                     input logic [31:0] ep);
      redir_vec_t r;
      r.name = n; r.valid = v; r.jmp = j; r.ne = ne; r.z = z;
      r.pc = pc; r.tgt = t; r.imm = imm; r.exp_acc = ea; r.exp_pop = ep;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // sel: 0 = accepted request addresses, 1 = popped ins_pc, 2 = popped ins_data
   task automatic check_at(input string name, input int sel, input int idx, input logic [31:0] exp);
      int sz;
      sz = (sel == 0) ? acc_q.size() : (sel == 1) ? pop_pc_q.size() : pop_data_q.size();
      if (idx < 0 || idx >= sz) begin
         n_checks++;
         n_fails++;
         $display("FAIL %s: entry %0d absent within cycle budget (have %0d), expected %h",
                  name, idx, sz, exp);
      end else begin
         check(name, (sel == 0) ? acc_q[idx] : (sel == 1) ? pop_pc_q[idx] : pop_data_q[idx], exp);
      end
   endtask

   task automatic clear_redir();
      redir_valid = 1'b0; redir_jmp = 1'b0; redir_ne = 1'b0; redir_z = 1'b0;
      redir_pc = '0; redir_target = '0; redir_imm = '0;
   endtask

   // One clock cycle starting and ending at a falling edge; memory answers one cycle after accept.
   task automatic cycle();
      logic        acc;
      logic        pop;
      logic [31:0] a;
      logic [31:0] ppc;
      logic [31:0] pdat;
      imem_rsp_valid = rsp_pend;
      imem_rsp_data  = rsp_pend ? mem_word(rsp_addr) : 32'h0;
      imem_req_ready = mem_ready;
      #1;
      acc  = imem_req_valid & imem_req_ready;
      a    = imem_req_addr;
      pop  = ins_valid & ins_ready;
      ppc  = ins_pc;
      pdat = ins_data;
      last_acc = acc;
      last_rsp = rsp_pend;
      @(posedge clk);
      rsp_pend = acc;
      rsp_addr = a;
      if (acc) acc_q.push_back(a);
      if (pop) begin
         pop_pc_q.push_back(ppc);
         pop_data_q.push_back(pdat);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_redir();
      rsp_pend = 1'b0; rsp_addr = '0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      mem_ready = 1'b1; imem_req_ready = 1'b1; ins_ready = 1'b1;
      acc_q.delete(); pop_pc_q.delete(); pop_data_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic apply_redir(input redir_vec_t v);
      redir_valid = v.valid; redir_jmp = v.jmp; redir_ne = v.ne; redir_z = v.z;
      redir_pc = v.pc; redir_target = v.tgt; redir_imm = v.imm;
      cycle();
      clear_redir();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int m;
      vecs[0] = mk("jmp",         1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC0_0010, 26'h000_0100, 16'h0000, 32'hB000_0400, 32'hB000_0400);
      vecs[1] = mk("bne_taken",   1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 26'h0,        16'hFFFC, 32'h0000_00F4, 32'h0000_00F4);
      vecs[2] = mk("bne_not",     1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 26'h0,        16'hFFFC, NT_ACC,        NT_POP);
      vecs[3] = mk("beq_taken",   1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 26'h0,        16'h0010, 32'h0000_0244, 32'h0000_0244);
      vecs[4] = mk("beq_not",     1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 26'h0,        16'h0010, NT_ACC,        NT_POP);
      vecs[5] = mk("beq_wrap",    1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 26'h0,        16'h7FFF, 32'h0001_FFF0, 32'h0001_FFF0);
      vecs[6] = mk("jmp_novalid", 1'b0, 1'b1, 1'b0, 1'b0, 32'hBFC0_0010, 26'h000_0100, 16'h0000, NT_ACC,        NT_POP);
      vecs[7] = mk("jmp_flags",   1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 26'h0AB_CDEF, 16'h0000, 32'h12AF_37BC, 32'h12AF_37BC);

      // Reset values while rst is held
      rst = 1'b1;
      clear_redir();
      rsp_pend = 1'b0; rsp_addr = '0; mem_ready = 1'b1; ins_ready = 1'b1;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      @(negedge clk); @(negedge clk);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
      check("rst_ins_data", ins_data, 32'd0);
      check("rst_ins_pc", ins_pc, 32'd0);

      // Sequential stream with memory and decode always ready
      do_reset();
      repeat (16) cycle();
      for (int i = 0; i < 8; i++) begin
         check_at($sformatf("seq_addr%0d", i), 0, i, RESET_PC + 32'(4 * i));
         check_at($sformatf("seq_pc%0d", i),   1, i, RESET_PC + 32'(4 * i));
         check_at($sformatf("seq_data%0d", i), 2, i, mem_word(RESET_PC + 32'(4 * i)));
      end

      // Decode stalled: credit limit holds requests at DEPTH, head stays put, nothing lost
      do_reset();
      ins_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (k >= 2) begin
            check($sformatf("stall_valid%0d", k), {31'b0, ins_valid}, 32'd1);
            check($sformatf("stall_pc%0d", k), ins_pc, RESET_PC);
            check($sformatf("stall_data%0d", k), ins_data, mem_word(RESET_PC));
         end
      end
      check("stall_req_count", acc_q.size(), 32'd2);
      ins_ready = 1'b1;
      repeat (12) cycle();
      for (int i = 0; i < 5; i++)
         check_at($sformatf("stall_resume_pc%0d", i), 1, i, RESET_PC + 32'(4 * i));

      // Redirect table: redirect lands with one old read in flight and a pop in the same cycle
      foreach (vecs[i]) begin
         do_reset();
         repeat (3) cycle();
         apply_redir(vecs[i]);
         n = acc_q.size();
         m = pop_pc_q.size();
         repeat (10) cycle();
         check_at({vecs[i].name, "_next_addr"}, 0, n, vecs[i].exp_acc);
         check_at({vecs[i].name, "_next_pc"},   1, m, vecs[i].exp_pop);
         check_at({vecs[i].name, "_next_data"}, 2, m, mem_word(vecs[i].exp_pop));
      end

      // Redirect in the same cycle as a response and a request accept
      do_reset();
      cycle();
      apply_redir(mk("same", 1'b1, 1'b1, 1'b0, 1'b0, 32'hBFC0_0000, 26'h000_0040, 16'h0, 32'h0, 32'h0));
      check("same_had_accept", {31'b0, last_acc}, 32'd1);
      check("same_had_rsp", {31'b0, last_rsp}, 32'd1);
      n = acc_q.size();
      m = pop_pc_q.size();
      check("same_no_pop_before", m, 32'd0);
      repeat (10) cycle();
      check_at("same_next_addr", 0, n, 32'hB000_0100);
      check_at("same_first_pc", 1, 0, 32'hB000_0100);
      check_at("same_first_data", 2, 0, mem_word(32'hB000_0100));
`ifdef IF_PERF_CNT_EN
      check("perf_flush_cnt", perf_flush_cnt, 32'd1);
`endif

      // PC wrap from the top of the address space
      do_reset();
      repeat (3) cycle();
      apply_redir(mk("wrap", 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 26'h3FF_FFFF, 16'h0, 32'h0, 32'h0));
      n = acc_q.size();
      m = pop_pc_q.size();
      repeat (12) cycle();
      check_at("wrap_addr_top", 0, n, 32'hFFFF_FFFC);
      check_at("wrap_addr_zero", 0, n + 1, 32'h0000_0000);
      check_at("wrap_pc_top", 1, m, 32'hFFFF_FFFC);
      check_at("wrap_pc_zero", 1, m + 1, 32'h0000_0000);
      check_at("wrap_data_zero", 2, m + 1, mem_word(32'h0000_0000));

      // Reset asserted mid-stream clears outputs at once and restarts from RESET_PC
      do_reset();
      repeat (5) cycle();
      rst = 1'b1;
      #1;
      check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("midrst_ins_valid", {31'b0, ins_valid}, 32'd0);
      check("midrst_ins_pc", ins_pc, 32'd0);
      do_reset();
      repeat (4) cycle();
      check_at("midrst_first_addr", 0, 0, RESET_PC);
      check_at("midrst_first_pc", 1, 0, RESET_PC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
